// File: rtl/rvfi_trap_revert_tracker.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_trap_revert_tracker
// Purpose  : Tracks how many instructions retired between an interrupt or
//            debug request becoming actionable and the core actually taking
//            the trap. Each trap retirement is packaged as an event (kind
//            bits, irq/mie snapshot, revert step counts, allowed flags) and
//            queued for the reference-model wrapper.
// Ports    : clk_i / rst_i            - clock, synchronous active-high reset
//            rvfi_valid_i             - one instruction retires this cycle
//            rvfi_intr_i              - retiring insn is first of irq handler
//            rvfi_dbg_entry_i         - retiring insn is first in debug mode
//            irq_i / mie_i            - pending irq lines and mie CSR
//            debug_req_i              - external debug request
//            evt_valid_o/evt_ready_i  - event queue head handshake
//            evt_*_o                  - head event fields (0 when empty)
//            overflow_o               - sticky: an event was dropped
// Revision : 1.0 - initial release
// ============================================================================
module rvfi_trap_revert_tracker #(
   parameter int  XLEN       = 32,
   parameter int  MAX_REVERT = 15,
   parameter int  FIFO_DEPTH = 4,
   localparam int CW         = $clog2(MAX_REVERT + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            rvfi_valid_i,
   input  logic            rvfi_intr_i,
   input  logic            rvfi_dbg_entry_i,
   input  logic [XLEN-1:0] irq_i,
   input  logic [XLEN-1:0] mie_i,
   input  logic            debug_req_i,
   output logic            evt_valid_o,
   input  logic            evt_ready_i,
   output logic            evt_intr_o,
   output logic            evt_dbg_o,
   output logic [XLEN-1:0] evt_irq_o,
   output logic [XLEN-1:0] evt_mie_o,
   output logic [CW-1:0]   evt_intr_revert_o,
   output logic [CW-1:0]   evt_dbg_revert_o,
   output logic            evt_intr_allowed_o,
   output logic            evt_dbg_allowed_o,
   output logic            overflow_o
);

   localparam int            AW          = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] C_CNT_MAX   = CW'(MAX_REVERT);
   localparam logic [AW:0]   C_FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

   typedef struct packed {
      logic            intr;
      logic            dbg;
      logic [XLEN-1:0] irq;
      logic [XLEN-1:0] mie;
      logic [CW-1:0]   intr_revert;
      logic [CW-1:0]   dbg_revert;
      logic            intr_allowed;
      logic            dbg_allowed;
   } evt_t;

   // ------------------------------------------------------------------------
   // Arm / revert counters
   // ------------------------------------------------------------------------
   logic          r_intr_armed;
   logic [CW-1:0] r_intr_cnt;
   logic          r_dbg_armed;
   logic [CW-1:0] r_dbg_cnt;

   logic w_intr_pend;
   logic w_intr_trap;
   logic w_dbg_trap;
   logic w_trap;

   assign w_intr_pend = |(irq_i & mie_i);
   assign w_intr_trap = rvfi_valid_i && rvfi_intr_i;
   assign w_dbg_trap  = rvfi_valid_i && rvfi_dbg_entry_i;
   assign w_trap      = w_intr_trap || w_dbg_trap;

   // Arming takes a cycle: the cycle pending first rises only sets armed, so
   // a retirement in that same cycle is not counted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_intr_armed <= 1'b0;
         r_intr_cnt   <= '0;
      end else if (w_intr_trap || !w_intr_pend) begin
         r_intr_armed <= 1'b0;
         r_intr_cnt   <= '0;
      end else if (!r_intr_armed) begin
         r_intr_armed <= 1'b1;
         r_intr_cnt   <= '0;
      end else if (rvfi_valid_i && (r_intr_cnt != C_CNT_MAX)) begin
         r_intr_cnt   <= r_intr_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_dbg_armed <= 1'b0;
         r_dbg_cnt   <= '0;
      end else if (w_dbg_trap || !debug_req_i) begin
         r_dbg_armed <= 1'b0;
         r_dbg_cnt   <= '0;
      end else if (!r_dbg_armed) begin
         r_dbg_armed <= 1'b1;
         r_dbg_cnt   <= '0;
      end else if (rvfi_valid_i && (r_dbg_cnt != C_CNT_MAX)) begin
         r_dbg_cnt   <= r_dbg_cnt + 1'b1;
      end
   end

   // Event snapshot uses the counter values before this cycle's update.
   evt_t w_new_evt;

   always_comb begin
      w_new_evt              = '0;
      w_new_evt.intr         = rvfi_intr_i;
      w_new_evt.dbg          = rvfi_dbg_entry_i;
      w_new_evt.irq          = irq_i;
      w_new_evt.mie          = mie_i;
      w_new_evt.intr_revert  = r_intr_armed ? r_intr_cnt : '0;
      w_new_evt.dbg_revert   = r_dbg_armed ? r_dbg_cnt : '0;
      w_new_evt.intr_allowed = r_intr_armed;
      w_new_evt.dbg_allowed  = r_dbg_armed;
   end

   // ------------------------------------------------------------------------
   // Event FIFO
   // ------------------------------------------------------------------------
   evt_t          r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;
   evt_t w_head;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == C_FIFO_FULL);
   assign w_pop   = !w_empty && evt_ready_i;
   // A pop in the same cycle frees a slot, so a full queue still accepts.
   assign w_push  = w_trap && (!w_full || w_pop);

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_new_evt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_trap && !w_push) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Head is masked to zero when empty so stale storage never leaks out.
   assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

   assign evt_valid_o        = !w_empty;
   assign evt_intr_o         = w_head.intr;
   assign evt_dbg_o          = w_head.dbg;
   assign evt_irq_o          = w_head.irq;
   assign evt_mie_o          = w_head.mie;
   assign evt_intr_revert_o  = w_head.intr_revert;
   assign evt_dbg_revert_o   = w_head.dbg_revert;
   assign evt_intr_allowed_o = w_head.intr_allowed;
   assign evt_dbg_allowed_o  = w_head.dbg_allowed;
   assign overflow_o         = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rvfi_trap_revert_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvfi_trap_revert_tracker
// Purpose  : Self-checking bench for rvfi_trap_revert_tracker. Expected
//            events are queued when a trap is driven and compared when the
//            DUT hands the head event out (valid && ready).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvfi_trap_revert_tracker;

   typedef struct packed {
      logic        intr;
      logic        dbg;
      logic [31:0] irq;
      logic [31:0] mie;
      logic [3:0]  irev;
      logic [3:0]  drev;
      logic        ia;
      logic        da;
   } evt_t;

   typedef struct {
      logic [31:0] irq;
      logic [31:0] mie;
      logic        dreq;
      int          nret;
      logic        t_intr;
      logic        t_dbg;
      logic [3:0]  e_irev;
      logic [3:0]  e_drev;
      logic        e_ia;
      logic        e_da;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rvfi_valid;
   logic        rvfi_intr;
   logic        rvfi_dbg_entry;
   logic [31:0] irq;
   logic [31:0] mie;
   logic        debug_req;
   logic        evt_valid;
   logic        evt_ready;
   logic        evt_intr;
   logic        evt_dbg;
   logic [31:0] evt_irq;
   logic [31:0] evt_mie;
   logic [3:0]  evt_intr_revert;
   logic [3:0]  evt_dbg_revert;
   logic        evt_intr_allowed;
   logic        evt_dbg_allowed;
   logic        overflow;

   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   evt_t exp_q[$];
   evt_t act_evt;
   vec_t tbl[8];

   always #5 clk = ~clk;

   rvfi_trap_revert_tracker dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .rvfi_valid_i       (rvfi_valid),
      .rvfi_intr_i        (rvfi_intr),
      .rvfi_dbg_entry_i   (rvfi_dbg_entry),
      .irq_i              (irq),
      .mie_i              (mie),
      .debug_req_i        (debug_req),
      .evt_valid_o        (evt_valid),
      .evt_ready_i        (evt_ready),
      .evt_intr_o         (evt_intr),
      .evt_dbg_o          (evt_dbg),
      .evt_irq_o          (evt_irq),
      .evt_mie_o          (evt_mie),
      .evt_intr_revert_o  (evt_intr_revert),
      .evt_dbg_revert_o   (evt_dbg_revert),
      .evt_intr_allowed_o (evt_intr_allowed),
      .evt_dbg_allowed_o  (evt_dbg_allowed),
      .overflow_o         (overflow)
   );

   assign act_evt = {evt_intr, evt_dbg, evt_irq, evt_mie, evt_intr_revert,
                     evt_dbg_revert, evt_intr_allowed, evt_dbg_allowed};

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic evt_t mk(input logic i, input logic d, input logic [31:0] q,
                               input logic [31:0] m, input logic [3:0] ir,
                               input logic [3:0] dr, input logic ia, input logic da);
      evt_t e;
      e = {i, d, q, m, ir, dr, ia, da};
      return e;
   endfunction

   // Inputs change 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rvfi_valid = 1'b0; rvfi_intr = 1'b0; rvfi_dbg_entry = 1'b0;
      irq = '0; mie = '0; debug_req = 1'b0;
   endtask

   // Scoreboard: compare the head each time the DUT hands one out.
   always @(negedge clk) begin
      if (!rst && evt_valid && evt_ready) begin
         if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL sb_unexpected: got %0h expected no event", act_evt);
         end else begin
            check("sb_event", act_evt, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //            irq       mie       dreq nret intr dbg  irev  drev  ia    da
      tbl[0] = '{32'h800, 32'h800, 1'b0, 3,  1'b1, 1'b0, 4'd3,  4'd0,  1'b1, 1'b0};
      tbl[1] = '{32'h800, 32'h800, 1'b0, 20, 1'b1, 1'b0, 4'd15, 4'd0,  1'b1, 1'b0};
      tbl[2] = '{32'h800, 32'h800, 1'b0, 0,  1'b1, 1'b0, 4'd0,  4'd0,  1'b1, 1'b0};
      tbl[3] = '{32'h0,   32'h0,   1'b1, 5,  1'b0, 1'b1, 4'd0,  4'd5,  1'b0, 1'b1};
      tbl[4] = '{32'h0,   32'h0,   1'b1, 15, 1'b0, 1'b1, 4'd0,  4'd15, 1'b0, 1'b1};
      tbl[5] = '{32'h5,   32'h4,   1'b0, 2,  1'b0, 1'b1, 4'd2,  4'd0,  1'b1, 1'b0};
      tbl[6] = '{32'hF0,  32'h0F,  1'b0, 4,  1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0};
      tbl[7] = '{32'h1,   32'h1,   1'b1, 6,  1'b1, 1'b1, 4'd6,  4'd6,  1'b1, 1'b1};

      rst = 1'b1; evt_ready = 1'b1; idle_inputs();
      step(); step();
      check("reset_valid", evt_valid, 0);
      check("reset_overflow", overflow, 0);
      check("reset_data", act_evt, 0);
      rst = 1'b0;

      // Table-driven: idle, arm cycle, nret retirements, trap.
      for (int i = 0; i < 8; i++) begin
         idle_inputs(); step();
         irq = tbl[i].irq; mie = tbl[i].mie; debug_req = tbl[i].dreq;
         step();
         rvfi_valid = 1'b1;
         for (int k = 0; k < tbl[i].nret; k++) step();
         rvfi_intr = tbl[i].t_intr; rvfi_dbg_entry = tbl[i].t_dbg;
         exp_q.push_back(mk(tbl[i].t_intr, tbl[i].t_dbg, tbl[i].irq, tbl[i].mie,
                            tbl[i].e_irev, tbl[i].e_drev, tbl[i].e_ia, tbl[i].e_da));
         step();
         check($sformatf("vec%0d_latency", i), evt_valid, 1);
      end
      idle_inputs(); step();

      // Disarm then spurious trap.
      irq = 32'h800; mie = 32'h800; step();
      rvfi_valid = 1'b1; step(); step();
      mie = '0; step(); step();
      rvfi_intr = 1'b1;
      exp_q.push_back(mk(1'b1, 1'b0, 32'h800, 32'h0, 4'd0, 4'd0, 1'b0, 1'b0));
      step();
      idle_inputs(); step();

      // Simultaneous: intr counts 2, debug arms a cycle later and counts 1.
      irq = 32'h800; mie = 32'h800; step();
      debug_req = 1'b1; rvfi_valid = 1'b1; step();
      step();
      rvfi_intr = 1'b1; rvfi_dbg_entry = 1'b1;
      exp_q.push_back(mk(1'b1, 1'b1, 32'h800, 32'h800, 4'd2, 4'd1, 1'b1, 1'b1));
      step();
      idle_inputs(); step();
      check("simul_single_event", evt_valid, 0);

      // Backpressure: 5 traps into a 4-deep queue, fifth dropped.
      evt_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         rvfi_valid = 1'b1; rvfi_intr = 1'b1; irq = 32'(i); mie = '0;
         if (i <= 4) exp_q.push_back(mk(1'b1, 1'b0, 32'(i), 32'h0, 4'd0, 4'd0, 1'b0, 1'b0));
         step();
      end
      idle_inputs();
      check("bp_overflow", overflow, 1);
      check("bp_valid", evt_valid, 1);
      step(); step();
      check("bp_head_stable", evt_irq, 32'h1);
      // Full queue plus a pop in the same cycle accepts the new trap.
      evt_ready = 1'b1; rvfi_valid = 1'b1; rvfi_intr = 1'b1; irq = 32'h6;
      exp_q.push_back(mk(1'b1, 1'b0, 32'h6, 32'h0, 4'd0, 4'd0, 1'b0, 1'b0));
      step();
      idle_inputs();
      for (int k = 0; k < 6; k++) step();
      check("bp_overflow_sticky", overflow, 1);
      check("bp_drained", evt_valid, 0);
      check("bp_sb_empty", exp_q.size(), 0);

      // Full throughput: a trap every cycle, popped every cycle.
      for (int i = 0; i < 6; i++) begin
         rvfi_valid = 1'b1; rvfi_intr = 1'b1; irq = 32'h100 + 32'(i); mie = '0;
         exp_q.push_back(mk(1'b1, 1'b0, 32'h100 + 32'(i), 32'h0, 4'd0, 4'd0, 1'b0, 1'b0));
         step();
      end
      idle_inputs(); step(); step();
      check("tp_sb_empty", exp_q.size(), 0);
      check("tp_overflow_sticky", overflow, 1);

      // Reset mid-operation with queued events and an armed counter.
      evt_ready = 1'b0;
      irq = 32'h8; mie = 32'h8; step();
      rvfi_valid = 1'b1; step(); step();
      rvfi_dbg_entry = 1'b1; step(); step();
      check("rst_pre_valid", evt_valid, 1);
      rvfi_dbg_entry = 1'b0; rvfi_intr = 1'b1; rst = 1'b1;
      step();
      check("rst_valid", evt_valid, 0);
      check("rst_overflow", overflow, 0);
      check("rst_data", act_evt, 0);
      rst = 1'b0; evt_ready = 1'b1;
      // Armed flag cleared by reset: immediate trap is spurious.
      exp_q.push_back(mk(1'b1, 1'b0, 32'h8, 32'h8, 4'd0, 4'd0, 1'b0, 1'b0));
      step();
      idle_inputs(); step(); step();
      check("final_sb_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rvfi_trap_revert_tracker.md
# rvfi_trap_revert_tracker

Cycle-accurate RTL tracker between the core's RVFI retirement stream and the Spike reference-model wrapper. It counts how many instructions retired after an interrupt or debug request became actionable but before the core took the trap. It packages each trap as an event carrying the revert step count, the irq/mie values and the allowed flags. The wrapper pops events and passes them to its interrupt and debug entry calls (`num_revert_steps`, `interrupt_allowed`, `debug_allowed`).

## Interface

Parameters:
- `XLEN`, 32, width of `irq_i`/`mie_i` and event data.
- `MAX_REVERT`, 15, saturation value of both step counters; counter width `CW = $clog2(MAX_REVERT+1)`.
- `FIFO_DEPTH`, 4, event queue entries (power of two, ≥2).

Ports:
- `clk_i` in 1: sole clock; all state updates on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `rvfi_valid_i` in 1: one instruction retires this cycle.
- `rvfi_intr_i` in 1: the retiring instruction is the first instruction of an interrupt handler; qualified by `rvfi_valid_i`.
- `rvfi_dbg_entry_i` in 1: the retiring instruction is the first instruction in debug mode; qualified by `rvfi_valid_i`.
- `irq_i` in XLEN: core mip/irq lines, sampled every cycle.
- `mie_i` in XLEN: core mie CSR value, sampled every cycle.
- `debug_req_i` in 1: external debug request.
- `evt_valid_o` out 1: queue head valid.
- `evt_ready_i` in 1: consumer accepts head.
- `evt_intr_o` out 1: head is an interrupt trap.
- `evt_dbg_o` out 1: head is a debug entry.
- `evt_irq_o` out XLEN: `irq_i` at trap retirement.
- `evt_mie_o` out XLEN: `mie_i` at trap retirement.
- `evt_intr_revert_o` out CW: interrupt revert steps.
- `evt_dbg_revert_o` out CW: debug revert steps.
- `evt_intr_allowed_o` out 1: interrupt was armed when taken.
- `evt_dbg_allowed_o` out 1: debug was armed when taken.
- `overflow_o` out 1: sticky, event dropped because queue full.

## Operation

- Interrupt arm logic, per cycle, in priority order:
  - If `rvfi_valid_i && rvfi_intr_i`: build event, then `intr_armed<=0`, `intr_cnt<=0`.
  - Else if `(irq_i & mie_i)==0`: `intr_armed<=0`, `intr_cnt<=0`.
  - Else if `!intr_armed`: `intr_armed<=1`, `intr_cnt<=0`.
  - Else if `rvfi_valid_i`: `intr_cnt<=min(intr_cnt+1, MAX_REVERT)`.
- Debug arm logic is identical, with `debug_req_i` in place of `irq_i & mie_i` and `rvfi_dbg_entry_i` in place of `rvfi_intr_i`.
- Event build:
  - Triggered when `rvfi_valid_i && (rvfi_intr_i || rvfi_dbg_entry_i)`.
  - Fields: `intr=rvfi_intr_i`, `dbg=rvfi_dbg_entry_i`, `irq=irq_i`, `mie=mie_i`.
  - `intr_revert = intr_armed ? intr_cnt : 0`; `intr_allowed = intr_armed`.
  - Debug fields are formed the same way from the debug counter.
  - Counts use the pre-update register values.
- Both trap flags in one retirement produce one event with both kind bits set; both counters clear.
- Queue: synchronous FIFO of `FIFO_DEPTH` entries.
  - Pop when `evt_valid_o && evt_ready_i`.
  - A push is accepted when not full, or when full with a pop in the same cycle.
  - A push while full without a pop is dropped, and `overflow_o<=1` until reset.
- Outputs present the head entry. All `evt_*` data outputs are 0 when empty.
- A trap retirement while not armed (spurious) still pushes an event with `allowed=0`, revert 0.

## Timing

- Reset: all counters 0, armed flags 0, FIFO empty. Every output is 0.
- Reset mid-operation: queued events are discarded. No event is produced for a trap retiring in the reset cycle.
- Latency: trap retirement in cycle N gives `evt_valid_o=1` in cycle N+1 if the queue was empty.
- Arming takes one cycle. A retirement in the same cycle that pending first rises is not counted. A retirement in the next cycle counts as 1.
- Counter saturation: at `MAX_REVERT` the counter holds; it never wraps.
- Head data is stable while `evt_valid_o && !evt_ready_i`.
- Full throughput: one push and one pop per cycle.

## Test plan

- Basic interrupt:
  - Stimulus: `irq_i=mie_i=0x800` at cycle 0; retirements at cycles 1, 2, 3; `rvfi_intr_i` retirement at cycle 4.
  - Response: cycle 5 shows `evt_valid_o=1`, `evt_intr_o=1`, `evt_intr_revert_o=3`, `evt_intr_allowed_o=1`, `evt_irq_o=0x800`.
- Saturation:
  - Stimulus: armed interrupt with 20 retirements, then trap.
  - Response: `evt_intr_revert_o=15`.
- Disarm then spurious trap:
  - Stimulus: `mie_i` cleared after 2 retirements; later trap retirement.
  - Response: `evt_intr_allowed_o=0`, revert 0.
- Simultaneous:
  - Stimulus: interrupt armed with 2 retirements, debug armed with 1; one retirement with both flags.
  - Response: single event with `intr=1`, `dbg=1`, revert 2 and 1.
- Backpressure:
  - Stimulus: `evt_ready_i=0`; 5 traps.
  - Response: 4 events held in order, `overflow_o=1`. After raising ready, the 4 events drain FIFO order and `overflow_o` stays 1.
- Reset:
  - Stimulus: 2 queued events, then `rst_i` pulsed for one cycle.
  - Response: next cycle has all outputs 0 and counters 0.
